// File: rtl/polar_bit_alloc_if.sv
// Stream interface of the polar encoder bit allocator.
//   in_valid/in_data/in_last/in_ready : W-bit information-word input stream
//   out_valid/out_data/out_ready      : N-bit u vector towards the generator stage
//   err_len                           : one-cycle frame-length violation pulse
// Modport slave is the allocator side, master is the producer/consumer side.
interface polar_bit_alloc_if #(
  parameter int unsigned N = 256,
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;
  logic         err_len;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, err_len
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, err_len
  );
endinterface

// File: rtl/polar_bit_alloc.sv
// Polar encoder bit allocator: collects K information bits arriving as W-bit words and
// scatters them into an N-bit source vector u, with zeros at frozen positions.
// One frame can be collected while the previous u vector waits in the output register.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : polar_bit_alloc_if.slave (input word stream, u vector output, err_len pulse)
module polar_bit_alloc #(
  parameter int unsigned  N         = 256,
  parameter int unsigned  K         = 128,
  parameter int unsigned  W         = 8,
  parameter logic [N-1:0] INFO_MASK = {{128{1'b1}}, {128{1'b0}}}
) (
  input logic              clk,
  input logic              rst,
  polar_bit_alloc_if.slave bus
);

  localparam int unsigned Words = K / W;
  localparam int unsigned CntW  = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned IdxW  = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [0:0] {StCollect, StFull} state_e;

  // Number of information positions strictly below position p, i.e. the info-bit index
  // that lands on p when INFO_MASK[p] is set.
  function automatic int unsigned info_index(input int unsigned p);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < p; i++) begin
      if (INFO_MASK[i]) n++;
    end
    return n;
  endfunction

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [K-1:0]    buf_q, buf_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [N-1:0]    out_data_q, out_data_d;
  logic            err_q, err_d;

  logic         accept;
  logic         last_word;
  logic         slot_free;
  logic         load;
  logic [N-1:0] scattered;

  // Static scatter: pure wiring, resolved at elaboration.
  for (genvar p = 0; p < N; p++) begin : g_scatter
    if (INFO_MASK[p]) begin : g_info
      localparam logic [IdxW-1:0] Idx = IdxW'(info_index(p));
      assign scattered[p] = buf_q[Idx];
    end else begin : g_frozen
      assign scattered[p] = 1'b0;
    end
  end

  // in_ready_q is only ever high in StCollect, so accept implies collecting.
  assign accept    = bus.in_valid && in_ready_q;
  assign last_word = (cnt_q == CntW'(Words - 1));
  assign slot_free = !out_valid_q || bus.out_ready;
  assign load      = (state_q == StFull) && slot_free;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCollect;
      cnt_q       <= '0;
      buf_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StCollect: if (accept && bus.in_last && last_word) state_d = StFull;
      StFull:    if (slot_free) state_d = StCollect;
      default:   state_d = StCollect;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    err_d       = 1'b0;
    in_ready_d  = (state_d == StCollect);
    out_valid_d = load || (out_valid_q && !bus.out_ready);
    out_data_d  = load ? scattered : out_data_q;

    if (accept) begin
      for (int unsigned c = 0; c < Words; c++) begin
        if (cnt_q == CntW'(c)) buf_d[c*W +: W] = bus.in_data;
      end
      // A good frame and both length errors all restart the word count; an erroneous
      // frame never reaches StFull so its partial contents are simply overwritten.
      if (bus.in_last || last_word) cnt_d = '0;
      else                          cnt_d = cnt_q + 1'b1;
      err_d = (bus.in_last != last_word);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.err_len   = err_q;

endmodule

// File: tb/tb_polar_bit_alloc.sv
// Self-checking bench for polar_bit_alloc: table-driven frames, hand-written multi-cycle
// sequences (latency, back-to-back, backpressure, mid-frame reset), randomized frames
// against a frame-level reference model, and a second instance with an alternating mask.
module tb_polar_bit_alloc;

  localparam int unsigned N     = 256;
  localparam int unsigned K     = 128;
  localparam int unsigned W     = 8;
  localparam int          Words = 16;
  localparam logic [N-1:0] DefMask = {{128{1'b1}}, {128{1'b0}}};
  localparam logic [N-1:0] AltMask = {128{2'b10}};
  localparam logic [K-1:0] Seq     = 128'h100F0E0D0C0B0A090807060504030201;

  typedef struct {
    logic [K-1:0] bits;
    int           nwords;
    int           last_at;
    logic         exp_err;
    logic [N-1:0] exp_out;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  polar_bit_alloc_if #(.N(N), .W(W)) u ();
  polar_bit_alloc_if #(.N(N), .W(W)) u2 ();

  polar_bit_alloc #(.N(N), .K(K), .W(W), .INFO_MASK(DefMask)) dut (
    .clk(clk), .rst(rst), .bus(u)
  );
  polar_bit_alloc #(.N(N), .K(K), .W(W), .INFO_MASK(AltMask)) dut_alt (
    .clk(clk), .rst(rst), .bus(u2)
  );

  logic [1:0] or_mode = 2'd1;  // 0: hold off, 1: always ready, 2: random
  logic       rnd_or  = 1'b1;
  assign u.out_ready  = (or_mode == 2'd2) ? rnd_or : or_mode[0];
  assign u2.out_ready = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int err_seen = 0;
  int exp_err = 0;
  int m_c = 0;
  logic [K-1:0] m_buf = '0;
  logic [N-1:0] exp_q[$];

  vec_t tbl[7];
  logic [K-1:0] ra, rb;
  logic [N-1:0] ea, eb;
  int t0, ebase, kind, lw;

  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(negedge clk);
    rnd_or = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_scatter(input logic [K-1:0] bits,
                                               input logic [N-1:0] mask);
    logic [N-1:0] v;
    int j;
    v = '0;
    j = 0;
    for (int p = 0; p < N; p++) begin
      if (mask[p]) begin
        v[p] = bits[j];
        j++;
      end
    end
    return v;
  endfunction

  function automatic vec_t mk(input logic [K-1:0] bits, input int nw, input int la,
                              input logic e, input logic [N-1:0] o);
    vec_t v;
    v.bits = bits; v.nwords = nw; v.last_at = la; v.exp_err = e; v.exp_out = o;
    return v;
  endfunction

  // Frame-level model of the accept rules.
  task automatic model_accept(input logic [W-1:0] d, input logic last);
    m_buf[m_c*W +: W] = d;
    if (last && m_c == Words - 1) begin
      exp_q.push_back(ref_scatter(m_buf, DefMask));
      m_c = 0;
    end else if (last || m_c == Words - 1) begin
      exp_err++;
      m_c = 0;
    end else begin
      m_c++;
    end
  endtask

  // Monitor: every output handshake is checked against the model queue.
  logic err_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (u.out_valid && u.out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame: got %h expected no frame", u.out_data);
        end else begin
          check("frame_vs_model", u.out_data, exp_q.pop_front());
        end
      end
      if (u.err_len) begin
        err_seen++;
        check("err_len_one_cycle", N'(err_prev), '0);
      end
      err_prev = u.err_len;
    end else begin
      err_prev = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [W-1:0] d, input logic last);
    int t;
    u.in_valid = 1'b1;
    u.in_data  = d;
    u.in_last  = last;
    t = 0;
    while (u.in_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout: in_ready low for %0d cycles, required 1", t);
    end else begin
      @(negedge clk);
      model_accept(d, last);
      acc_cyc = cyc;
    end
    u.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [K-1:0] bits, input int nwords, input int last_at,
                            input bit idle);
    for (int w = 0; w < nwords; w++) begin
      if (idle && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      send_word(bits[w*W +: W], w == last_at);
    end
  endtask

  task automatic wait_valid(input string name);
    int t;
    t = 0;
    while (u.out_valid !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: out_valid low for %0d cycles, required 1", name, t);
    end
  endtask

  task automatic send2(input logic [K-1:0] bits);
    int t;
    for (int w = 0; w < Words; w++) begin
      u2.in_valid = 1'b1;
      u2.in_data  = bits[w*W +: W];
      u2.in_last  = (w == Words - 1);
      t = 0;
      while (u2.in_ready !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        vectors++;
        miscompares++;
        $display("FAIL alt_in_ready_timeout: in_ready low %0d cycles, required 1", t);
      end
      @(negedge clk);
    end
    u2.in_valid = 1'b0;
  endtask

  task automatic wait_valid2(input logic [N-1:0] exp, input string name);
    int t;
    t = 0;
    while (u2.out_valid !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check(name, u2.out_data, exp);
  endtask

  initial begin
    u.in_valid = 1'b0; u.in_data = '0; u.in_last = 1'b0;
    u2.in_valid = 1'b0; u2.in_data = '0; u2.in_last = 1'b0;

    tbl[0] = mk(Seq, 16, 15, 1'b0, {128'h100F0E0D0C0B0A090807060504030201, 128'h0});
    tbl[1] = mk('0, 16, 15, 1'b0, '0);
    tbl[2] = mk({K{1'b1}}, 16, 15, 1'b0, {{128{1'b1}}, 128'h0});
    tbl[3] = mk(128'hDEADBEEF_01234567_89ABCDEF_A5A55A5A, 16, 15, 1'b0,
                {128'hDEADBEEF_01234567_89ABCDEF_A5A55A5A, 128'h0});
    tbl[4] = mk(Seq, 6, 5, 1'b1, '0);
    tbl[5] = mk(Seq, 16, -1, 1'b1, '0);
    tbl[6] = mk(Seq, 16, 15, 1'b0, {128'h100F0E0D0C0B0A090807060504030201, 128'h0});

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_out_valid", N'(u.out_valid), '0);
    check("rst_out_data", u.out_data, '0);
    check("rst_err_len", N'(u.err_len), '0);
    check("rst_in_ready", N'(u.in_ready), '0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", N'(u.in_ready), N'(1));

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      ebase = err_seen;
      send_frame(tbl[i].bits, tbl[i].nwords, tbl[i].last_at, 1'b0);
      if (!tbl[i].exp_err) begin
        wait_valid($sformatf("table%0d", i));
        check($sformatf("table%0d_out_data", i), u.out_data, tbl[i].exp_out);
      end else begin
        repeat (3) @(negedge clk);
        check($sformatf("table%0d_err_pulses", i), N'(err_seen), N'(ebase + 1));
        check($sformatf("table%0d_no_out_valid", i), N'(u.out_valid), '0);
      end
      @(negedge clk);
    end

    // Latency: FULL right after the last accept, out_valid one edge later
    for (int w = 0; w < Words - 1; w++) send_word(Seq[w*W +: W], 1'b0);
    send_word(Seq[(Words-1)*W +: W], 1'b1);
    check("lat_full_in_ready", N'(u.in_ready), '0);
    check("lat_full_out_valid", N'(u.out_valid), '0);
    @(negedge clk);
    check("lat_out_valid", N'(u.out_valid), N'(1));
    check("lat_in_ready_back", N'(u.in_ready), N'(1));
    check("lat_out_data", u.out_data, {Seq, 128'h0});
    repeat (2) @(negedge clk);

    // Back-to-back: three frames, one every 17 cycles
    ra = {$urandom, $urandom, $urandom, $urandom};
    send_word(ra[W-1:0], 1'b0);
    t0 = acc_cyc;
    for (int w = 1; w < 3 * Words; w++) send_word(ra[(w % Words)*W +: W], (w % Words) == 15);
    check("b2b_span_cycles", N'(acc_cyc - t0), N'(49));
    repeat (4) @(negedge clk);

    // Backpressure: second frame collected while the first is held
    or_mode = 2'd0;
    ra = {$urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom};
    ea = ref_scatter(ra, DefMask);
    eb = ref_scatter(rb, DefMask);
    send_frame(ra, 16, 15, 1'b0);
    wait_valid("bp_first");
    check("bp_first_data", u.out_data, ea);
    send_frame(rb, 16, 15, 1'b0);
    repeat (3) @(negedge clk);
    check("bp_full_in_ready", N'(u.in_ready), '0);
    check("bp_held_valid", N'(u.out_valid), N'(1));
    check("bp_held_data", u.out_data, ea);
    or_mode = 2'd1;
    @(negedge clk);
    check("bp_swap_valid", N'(u.out_valid), N'(1));
    check("bp_swap_data", u.out_data, eb);
    check("bp_swap_in_ready", N'(u.in_ready), N'(1));
    @(negedge clk);
    check("bp_drained", N'(u.out_valid), '0);

    // Reset after word 9 of a frame
    ra = {$urandom, $urandom, $urandom, $urandom};
    send_frame(ra, 10, -1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    m_c = 0;
    exp_q.delete();
    check("midrst_out_valid", N'(u.out_valid), '0);
    check("midrst_out_data", u.out_data, '0);
    check("midrst_err_len", N'(u.err_len), '0);
    check("midrst_in_ready", N'(u.in_ready), '0);
    rst = 1'b0;
    @(negedge clk);
    send_frame(Seq, 16, 15, 1'b0);
    wait_valid("midrst_fresh");
    check("midrst_fresh_data", u.out_data, {Seq, 128'h0});
    repeat (2) @(negedge clk);

    // Randomized frames with idles, length errors and random out_ready
    or_mode = 2'd2;
    for (int f = 0; f < 40; f++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        lw = $urandom_range(0, 14);
        send_frame(ra, lw + 1, lw, 1'b1);
      end else if (kind == 1) begin
        send_frame(ra, 16, -1, 1'b1);
      end else begin
        send_frame(ra, 16, 15, 1'b1);
      end
    end
    or_mode = 2'd1;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("rand_frames_drained", N'(exp_q.size()), '0);
    check("rand_err_count", N'(err_seen), N'(exp_err));

    // Alternating mask instance
    send2({K{1'b1}});
    wait_valid2({128{2'b10}}, "alt_all_ones");
    repeat (2) @(negedge clk);
    ra = {$urandom, $urandom, $urandom, $urandom};
    send2(ra);
    wait_valid2(ref_scatter(ra, AltMask), "alt_random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/polar_bit_alloc.md
# polar_bit_alloc

Upstream stage of the polar encoder: collects K information bits arriving as W-bit words over a valid/ready stream and scatters them into an N-bit source vector u, writing zeros at frozen positions. The registered u vector drives the data_in port of the combinational generator-matrix stage, and that stage's output feeds the downstream consumer. Holds one frame in collection and one in the output register, so the next frame can arrive while the current u vector waits for the consumer.

## Interface
- N, 256, code length; must be a power of two.
- K, 128, information bits per frame; K % W == 0.
- W, 8, input word width.
- INFO_MASK, {{128{1'b1}},{128{1'b0}}}, N-bit constant; bit p = 1 marks an information position. Popcount must equal K.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_data  in  W  info bits; bit 0 is the lowest-index info bit of the word.
- in_last  in  1  marks the final word of a frame.
- in_ready  out  1  block accepts the word this cycle.
- out_valid  out  1  out_data holds a complete u vector.
- out_data  out  N  u vector; feeds the generator stage data_in.
- out_ready  in  1  consumer accepts out_data.
- err_len  out  1  one-cycle pulse on a frame-length violation.

## Operation
- Accept occurs when in_valid && in_ready. Word index c counts 0..K/W-1. The word with index c supplies info bits [c*W +: W].
- Info bit j goes to the j-th lowest position p where INFO_MASK[p] = 1. This is a static scatter computed at elaboration from prefix popcounts of INFO_MASK. All positions with INFO_MASK[p] = 0 output 0.
- States:
  - COLLECT: in_ready = 1.
  - FULL: in_ready = 0; the collect buffer holds K bits.
- COLLECT -> FULL: on accepting word c = K/W-1 with in_last = 1.
- FULL -> COLLECT: when the output slot is free (!out_valid || out_ready). The scattered buffer loads into out_data, out_valid is set, and c resets to 0.
- Output handshake: out_valid clears on out_ready unless a new load occurs in the same cycle. A load and a drain in the same cycle leave out_valid = 1 with the new data.
- Length errors: the frame is discarded, c resets to 0, err_len pulses, and the state stays COLLECT. Two cases:
  - in_last = 1 accepted with c < K/W-1.
  - Word c = K/W-1 accepted with in_last = 0.
- Rule: out_data is only ever written from a complete, error-free frame.

## Timing
- Reset values: out_valid = 0, out_data = 0, err_len = 0, in_ready = 0, state = COLLECT, c = 0. in_ready is 1 from the first cycle after rst deasserts. in_ready is registered.
- Latency: the final accept at edge t makes state FULL after t. If the output slot is free, out_valid = 1 after edge t+1.
- Throughput:
  - Best case is K/W+1 cycles per frame.
  - One mandatory bubble: the FULL cycle, where in_ready = 0.
  - Frame n+1 may collect while frame n is held in out_data.
- Backpressure: while FULL and out_valid && !out_ready, the block stays FULL and in_ready stays 0. Nothing is dropped.
- err_len asserts in the cycle after the offending accept and lasts exactly one cycle.
- rst mid-frame: the partial frame and any held out_data are discarded. All outputs return to their reset values on the next edge.
- in_data and in_last are ignored when !in_valid || !in_ready.

## Test plan
- Defaults, 16 words 0x01..0x10, in_last on word 15, out_ready = 1 -> out_valid after edge t+1. out_data[255:128] = 128'h100F0E0D0C0B0A090807060504030201, out_data[127:0] = 0. Feeding this through the generator stage matches the golden model.
- Back-to-back frames with continuous in_valid, out_ready = 1 -> one frame every 17 cycles. in_ready low exactly 1 cycle per frame.
- out_ready = 0 after the first frame, then stream a second frame -> second frame fully collected, in_ready held 0 in FULL, first out_data unchanged. Raising out_ready swaps to the second frame on the next edge with out_valid staying 1.
- in_last on word 5 -> err_len pulse, no out_valid. The following correct frame is output intact. Repeat with in_last missing on word 15 -> same result.
- Alternating INFO_MASK (odd positions), K = 128, all-ones input -> out_data = {128{2'b10}}.
- rst asserted for 1 cycle after word 9 -> all outputs 0. A fresh 16-word frame afterwards produces the correct vector.
